// File: rtl/generation_sequencer_pkg.sv
// Shared definitions for the generation sequencer: FSM state encodings and
// the row-index width helper.
package generation_sequencer_pkg;

  // FSM state encodings, kept as plain constants for legacy tool flows
  typedef logic [1:0] gs_state_t;

  localparam gs_state_t StIdle = 2'd0;
  localparam gs_state_t StLoad = 2'd1;
  localparam gs_state_t StRun  = 2'd2;
  localparam gs_state_t StStep = 2'd3;

  // Width of the load row index; a single-row grid still needs one bit
  function automatic int unsigned row_idx_width(input int unsigned height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/generation_sequencer_tick_divider.sv
// Programmable tick divider: emits a one-cycle tick every tick_div+1 enabled
// clocks. The counter is held at zero whenever enable is low.
module tick_divider #(
  parameter int unsigned TICK_DIV_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [TICK_DIV_WIDTH-1:0] tick_div,
  output logic                      tick
);

  logic [TICK_DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Tick fires combinationally on the compare so the caller updates on this edge
  assign tick = enable && (cnt_q == tick_div);

  // Next count: clear when idle or on wrap, otherwise increment
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TICK_DIV_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/generation_sequencer.sv
// Generation sequencer: owns the generation register feeding the cell grid,
// loads an initial pattern row by row, and advances generations either
// free-running (divided tick) or one step at a time.
// Optional feature macro: STILL_LIFE_DETECT_EN adds a 'halted' output that
// stops free-running once the pattern stops changing.
module generation_sequencer
  import generation_sequencer_pkg::*;
#(
  parameter int unsigned GRID_WIDTH      = 8,
  parameter int unsigned GRID_HEIGHT     = 8,
  parameter int unsigned GEN_COUNT_WIDTH = 16,
  parameter int unsigned TICK_DIV_WIDTH  = 24
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [GRID_WIDTH-1:0]             load_row,
  input  logic                              run,
  input  logic                              step,
  input  logic [TICK_DIV_WIDTH-1:0]         tick_div,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_state,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state,
  output logic [GEN_COUNT_WIDTH-1:0]        gen_count,
  output logic                              state_valid,
  output logic                              busy
`ifdef STILL_LIFE_DETECT_EN
  ,
  output logic                              halted
`endif
);

  localparam int unsigned CellCount = GRID_WIDTH * GRID_HEIGHT;
  localparam int unsigned RowW      = row_idx_width(GRID_HEIGHT);

  gs_state_t                state_q, state_d;
  logic [RowW-1:0]          row_q, row_d;
  logic [CellCount-1:0]     grid_q, grid_d;
  logic [GEN_COUNT_WIDTH-1:0] gen_q, gen_d;
  logic                     valid_q, valid_d;

  logic beat;
  logic row_last;
  logic run_en;
  logic tick;
  logic run_allowed;

`ifdef STILL_LIFE_DETECT_EN
  logic halted_q, halted_d;
  logic still;

  assign halted      = halted_q;
  assign still       = (next_state == grid_q);
  assign run_allowed = run && !halted_q;
`else
  assign run_allowed = run;
`endif

  assign beat     = load_valid && load_ready;
  assign row_last = (row_q == RowW'(GRID_HEIGHT - 1));
  assign run_en   = (state_q == StRun);

  assign load_ready  = (state_q == StIdle) || (state_q == StLoad);
  assign busy        = (state_q != StIdle);
  assign grid_state  = grid_q;
  assign gen_count   = gen_q;
  assign state_valid = valid_q;

  tick_divider #(
    .TICK_DIV_WIDTH (TICK_DIV_WIDTH)
  ) u_tick_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (run_en),
    .tick_div (tick_div),
    .tick     (tick)
  );

  // Next-state logic for the FSM, row loader, generation register and counter
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    valid_d  = 1'b0;
`ifdef STILL_LIFE_DETECT_EN
    halted_d = halted_q;
`endif

    case (state_q)
      StIdle, StLoad: begin
        if (beat) begin
          // Only the addressed row is rewritten; others keep their contents
          for (int r = 0; r < int'(GRID_HEIGHT); r++) begin
            if (row_q == RowW'(r)) begin
              grid_d[r*GRID_WIDTH +: GRID_WIDTH] = load_row;
            end
          end
`ifdef STILL_LIFE_DETECT_EN
          halted_d = 1'b0;
`endif
          if (row_last) begin
            row_d   = '0;
            gen_d   = '0;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StLoad;
          end
        end else if (state_q == StIdle) begin
          // Mid-load, run and step are ignored
          if (step) begin
            state_d = StStep;
`ifdef STILL_LIFE_DETECT_EN
            halted_d = 1'b0;
`endif
          end else if (run_allowed) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        // A tick on the same edge as run falling still commits the update
        if (tick) begin
          grid_d  = next_state;
          gen_d   = gen_q + GEN_COUNT_WIDTH'(1);
          valid_d = 1'b1;
`ifdef STILL_LIFE_DETECT_EN
          if (still) begin
            halted_d = 1'b1;
            state_d  = StIdle;
          end
`endif
        end
        if (!run) begin
          state_d = StIdle;
        end
      end

      StStep: begin
        grid_d  = next_state;
        gen_d   = gen_q + GEN_COUNT_WIDTH'(1);
        valid_d = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      grid_q  <= '0;
      gen_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      grid_q  <= grid_d;
      gen_q   <= gen_d;
      valid_q <= valid_d;
    end
  end

`ifdef STILL_LIFE_DETECT_EN
  // Halt flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`endif

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed self-checking bench for generation_sequencer. A small Life model
// stands in for the combinational cell grid (dead cells beyond the border).
module tb_generation_sequencer;

  localparam int W = 8;
  localparam int H = 8;

  localparam logic [63:0] BlinkH = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BlinkV = 64'h0000_0008_0808_0000;
  localparam logic [63:0] XPat   = 64'h8142_2418_1824_4281;
  localparam logic [63:0] XMid   = 64'h0000_0008_1824_4281;
  localparam logic [63:0] Block  = 64'h0000_0018_1800_0000;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_row;
  logic        run;
  logic        step;
  logic [23:0] tick_div;
  logic [63:0] grid_state;
  logic [63:0] next_state;
  logic [15:0] gen_count;
  logic        state_valid;
  logic        busy;
`ifdef STILL_LIFE_DETECT_EN
  logic        halted;
`endif

  int n_checks = 0;
  int n_errors = 0;

  generation_sequencer #(
    .GRID_WIDTH      (W),
    .GRID_HEIGHT     (H),
    .GEN_COUNT_WIDTH (16),
    .TICK_DIV_WIDTH  (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_row    (load_row),
    .run         (run),
    .step        (step),
    .tick_div    (tick_div),
    .grid_state  (grid_state),
    .next_state  (next_state),
    .gen_count   (gen_count),
    .state_valid (state_valid),
    .busy        (busy)
`ifdef STILL_LIFE_DETECT_EN
    ,
    .halted      (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] life_next(input logic [63:0] s);
    logic [63:0] r;
    int n, yy, xx;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if (!(dy == 0 && dx == 0) && yy >= 0 && yy < H && xx >= 0 && xx < W) begin
              if (s[yy*W + xx]) n++;
            end
          end
        end
        r[y*W + x] = (n == 3) || (s[y*W + x] && n == 2);
      end
    end
    return r;
  endfunction

  always_comb next_state = life_next(grid_state);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle just after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_full(input logic [63:0] pat);
    for (int r = 0; r < H; r++) begin
      load_valid = 1'b1;
      load_row   = pat[r*W +: W];
      cyc(1);
    end
    load_valid = 1'b0;
    load_row   = '0;
  endtask

  initial begin
    int pulses;
    int bad;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_row   = '0;
    run        = 1'b0;
    step       = 1'b0;
    tick_div   = '0;

    // Reset values
    cyc(2);
    check_eq("rst_grid", grid_state, 64'h0);
    check_eq("rst_gen", 64'(gen_count), 64'h0);
    check_eq("rst_valid", 64'(state_valid), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_ready", 64'(load_ready), 64'h1);
    rst_n = 1'b1;
    cyc(1);
    check_eq("idle_ready", 64'(load_ready), 64'h1);

    // Blinker load, back-to-back beats
    load_valid = 1'b1;
    load_row   = 8'h00;
    cyc(1);
    check_eq("load_busy", 64'(busy), 64'h1);
    check_eq("load_novalid", 64'(state_valid), 64'h0);
    for (int r = 1; r < H; r++) begin
      load_row = BlinkH[r*W +: W];
      cyc(1);
    end
    load_valid = 1'b0;
    check_eq("load_grid", grid_state, BlinkH);
    check_eq("load_valid_pulse", 64'(state_valid), 64'h1);
    check_eq("load_gen", 64'(gen_count), 64'h0);
    check_eq("load_idle", 64'(busy), 64'h0);
    cyc(1);
    check_eq("load_valid_end", 64'(state_valid), 64'h0);

    // Single step
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check_eq("step_busy", 64'(busy), 64'h1);
    check_eq("step_ready", 64'(load_ready), 64'h0);
    check_eq("step_hold", grid_state, BlinkH);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (i == 0) begin
        check_eq("step_grid", grid_state, BlinkV);
        check_eq("step_gen", 64'(gen_count), 64'h1);
        check_eq("step_done", 64'(busy), 64'h0);
      end
      if (state_valid) pulses++;
    end
    check_eq("step_pulses", 64'(pulses), 64'h1);

    // Free-run, tick_div=3: one update every 4 clocks
    tick_div = 24'd3;
    run      = 1'b1;
    cyc(1);
    check_eq("run_busy", 64'(busy), 64'h1);
    check_eq("run_ready", 64'(load_ready), 64'h0);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (state_valid) pulses++;
      if (i == 3) check_eq("run_div_hold", grid_state, BlinkV);
      if (i == 4) check_eq("run_div_first", grid_state, BlinkH);
    end
    check_eq("run_div_pulses", 64'(pulses), 64'h4);
    check_eq("run_div_gen", 64'(gen_count), 64'h5);
    check_eq("run_div_grid", grid_state, BlinkV);
    run = 1'b0;
    cyc(1);
    check_eq("run_stop_busy", 64'(busy), 64'h0);
    check_eq("run_stop_gen", 64'(gen_count), 64'h5);

    // Free-run, tick_div=0: update every clock, including the edge run falls
    tick_div = 24'd0;
    run      = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_eq("run_t0_valid", 64'(state_valid), 64'h1);
    end
    run = 1'b0;
    cyc(1);
    check_eq("run_fall_valid", 64'(state_valid), 64'h1);
    check_eq("run_fall_gen", 64'(gen_count), 64'h9);
    check_eq("run_fall_grid", grid_state, BlinkV);
    check_eq("run_fall_busy", 64'(busy), 64'h0);

    // Load with a gap after row 3; run and step must be ignored meanwhile
    for (int r = 0; r < 4; r++) begin
      load_valid = 1'b1;
      load_row   = XPat[r*W +: W];
      cyc(1);
    end
    load_valid = 1'b0;
    check_eq("gap_partial", grid_state, XMid);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      run  = (i == 1);
      step = (i == 3);
      cyc(1);
      if (!busy || !load_ready || state_valid) bad++;
    end
    run  = 1'b0;
    step = 1'b0;
    check_eq("gap_ignored", 64'(bad), 64'h0);
    check_eq("gap_grid", grid_state, XMid);
    check_eq("gap_gen", 64'(gen_count), 64'h9);
    for (int r = 4; r < H; r++) begin
      load_valid = 1'b1;
      load_row   = XPat[r*W +: W];
      cyc(1);
    end
    load_valid = 1'b0;
    check_eq("gap_load_grid", grid_state, XPat);
    check_eq("gap_load_gen", 64'(gen_count), 64'h0);
    check_eq("gap_load_valid", 64'(state_valid), 64'h1);
    cyc(1);
    check_eq("gap_load_idle", 64'(busy), 64'h0);

    // Reset while running with gen_count=7
    load_full(BlinkH);
    tick_div = 24'd0;
    run      = 1'b1;
    cyc(1);
    cyc(7);
    check_eq("pre_rst_gen", 64'(gen_count), 64'h7);
    check_eq("pre_rst_grid", grid_state, BlinkV);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_grid", grid_state, 64'h0);
    check_eq("mid_rst_gen", 64'(gen_count), 64'h0);
    check_eq("mid_rst_busy", 64'(busy), 64'h0);
    check_eq("mid_rst_ready", 64'(load_ready), 64'h1);
    cyc(1);
    check_eq("mid_rst_noupd", grid_state, 64'h0);
    check_eq("mid_rst_novalid", 64'(state_valid), 64'h0);
    run   = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    check_eq("post_rst_idle", 64'(busy), 64'h0);
    check_eq("post_rst_gen", 64'(gen_count), 64'h0);

`ifdef STILL_LIFE_DETECT_EN
    // Still-life detection on a 2x2 block
    load_full(Block);
    check_eq("blk_halt_clr", 64'(halted), 64'h0);
    tick_div = 24'd0;
    run      = 1'b1;
    cyc(1);
    check_eq("blk_run_busy", 64'(busy), 64'h1);
    cyc(1);
    check_eq("blk_halted", 64'(halted), 64'h1);
    check_eq("blk_gen", 64'(gen_count), 64'h1);
    check_eq("blk_busy", 64'(busy), 64'h0);
    check_eq("blk_valid", 64'(state_valid), 64'h1);
    cyc(3);
    check_eq("blk_run_ignored", 64'(busy), 64'h0);
    check_eq("blk_gen_hold", 64'(gen_count), 64'h1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check_eq("blk_step_clr", 64'(halted), 64'h0);
    check_eq("blk_step_busy", 64'(busy), 64'h1);
    run = 1'b0;
    cyc(1);
    check_eq("blk_step_gen", 64'(gen_count), 64'h2);
    check_eq("blk_step_nohalt", 64'(halted), 64'h0);
    cyc(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/generation_sequencer.md
Name: generation_sequencer

Overview:
- Sequential front-end for the combinational cell grid. It owns the generation register, drives it onto the grid's input_state, and captures the grid's next_state on each generation tick.
- It accepts an initial pattern row by row over a valid/ready handshake.
- It supports free-running and single-step advance, with a programmable tick divider and a generation counter.

Parameters:
- GRID_WIDTH, 8, cells per row; must match the cell grid.
- GRID_HEIGHT, 8, rows; must match the cell grid.
- GEN_COUNT_WIDTH, 16, width of the generation counter.
- TICK_DIV_WIDTH, 24, width of the tick divider compare value.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  load_row holds a valid row.
- load_ready  out  1  sequencer can accept a row.
- load_row  in  GRID_WIDTH  row data; bit x is cell x.
- run  in  1  level; free-run while high.
- step  in  1  single-cycle pulse; advance exactly one generation.
- tick_div  in  TICK_DIV_WIDTH  clocks per generation, minus one.
- grid_state  out  GRID_WIDTH*GRID_HEIGHT  current generation; feeds the cell grid's input_state.
- next_state  in  GRID_WIDTH*GRID_HEIGHT  from the cell grid's next_state.
- gen_count  out  GEN_COUNT_WIDTH  generations since the last completed load.
- state_valid  out  1  one-cycle pulse when grid_state has just changed (load complete or generation update).
- busy  out  1  high in LOAD, RUN or STEP.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - Outputs: grid_state=0, gen_count=0, state_valid=0, busy=0, load_ready=1.
  - Internal: row index=0, tick counter=0, FSM=IDLE.
- FSM states: IDLE, LOAD, RUN, STEP.
- IDLE:
  - load_ready=1. A row is accepted when load_valid && load_ready.
  - On the first accepted beat: row 0 is written to grid_state[0 +: GRID_WIDTH], row index becomes 1, go to LOAD.
  - Priority when several inputs are active in the same cycle: load beat > step > run.
  - step=1 -> STEP. run=1 -> RUN with tick counter=0.
- LOAD:
  - load_ready=1. Each accepted beat writes row r to grid_state[GRID_WIDTH*r +: GRID_WIDTH].
  - Beat for row GRID_HEIGHT-1: row index=0, gen_count=0, state_valid pulses the next cycle, go to IDLE.
  - run and step are ignored. Gaps (load_valid low) are allowed indefinitely.
  - Rows not yet rewritten keep their old contents until overwritten.
- RUN:
  - load_ready=0. The tick counter increments each clock.
  - When tick counter == tick_div: grid_state<=next_state, gen_count+=1 (wraps modulo 2^GEN_COUNT_WIDTH), state_valid pulses, tick counter=0.
  - tick_div=0 means an update every clock.
  - run low, sampled at a clock edge: go to IDLE without updating; tick counter cleared.
  - If run falls on the same edge as a tick compare, the update still happens.
  - step is ignored in RUN.
- STEP:
  - One cycle long, load_ready=0.
  - grid_state<=next_state, gen_count+=1, state_valid pulses, return to IDLE.
  - tick_div has no effect.
- Latency:
  - grid_state changes on the clock edge of the update.
  - state_valid is asserted in the cycle immediately following that edge, for one cycle.
  - next_state is purely combinational from grid_state, so one clock is sufficient.
- Reset mid-LOAD or mid-RUN: everything returns to reset values immediately; no partial state is retained.

Optional Feature:
- Macro: STILL_LIFE_DETECT_EN.
- Defined:
  - Adds output port halted (1 bit, reset 0).
  - In RUN, at a tick where next_state == grid_state: the update occurs as normal, gen_count increments, halted<=1, FSM -> IDLE even if run stays high.
  - While halted=1, run is ignored. halted clears on the first accepted load beat, on step, or on rst_n.
  - STEP never sets halted.
- Not defined: no halted port; RUN continues indefinitely on static patterns.

Decomposition:
- Package generation_sequencer_pkg: FSM state enum (IDLE, LOAD, RUN, STEP) and a localparam function for the row-index width, clog2(GRID_HEIGHT) with a minimum of 1.
- One sub-module: tick_divider. Inputs: clk, rst_n, enable, tick_div. Output: tick pulse. Its counter clears when enable is low.

Test Plan:
- Load a blinker (rows 3 = 8'b00011100, others 0) with load_valid held high for 8 beats -> state_valid pulse one cycle after beat 8; gen_count=0; grid_state matches the pattern.
- Blinker loaded, step pulse -> one cycle later row 2/3/4 bit 3 set (vertical); gen_count=1; exactly one state_valid pulse.
- run=1, tick_div=3 on the blinker -> updates every 4 clocks; after 16 clocks gen_count=4 and the pattern equals the original.
- Deassert load_valid for 5 cycles mid-load (after row 3), assert run and step during the gap -> both ignored; load completes correctly; FSM returns to IDLE.
- rst_n low for one cycle while in RUN with gen_count=7 -> all outputs at reset values immediately; no update occurs on the next edge.
- STILL_LIFE_DETECT_EN with a 2x2 block, run=1, tick_div=0 -> after one tick halted=1, gen_count=1, busy=0; run stays ignored until a step pulse.
